// File: rtl/usb4_lane_encoder_gen.sv
// USB4 transmit lane encoder: Gen2 64b/66b, Gen3 128b/132b, Gen4 byte pass-through.
// Define USB4_ENC_STATS_EN to add the sym_count handover counter output.
module usb4_lane_encoder_gen #(
    parameter int NUM_LANES = 2,
    parameter int SYM_W     = 132
) (
    input  logic                       enc_clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 gen_speed,
    input  logic [3:0]                 d_sel,
    input  logic [8*NUM_LANES-1:0]     lane_tx,
    output logic                       in_ready,
    output logic [SYM_W*NUM_LANES-1:0] sym_out,
    output logic                       sym_valid,
    input  logic                       sym_ready,
    output logic                       new_sym,
    output logic                       abort
`ifdef USB4_ENC_STATS_EN
    ,
    output logic [15:0]                sym_count
`endif
);

    localparam int TOT = SYM_W * NUM_LANES;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]     r_state;
    logic [3:0]     r_byte_cnt;
    logic           r_hdr_sel;
    logic [1:0]     r_gen_q;
    logic [TOT-1:0] r_stage;
    logic [TOT-1:0] r_sym;
    logic           r_sym_valid;
    logic           r_new_sym;
    logic           r_abort;

    logic [3:0]     w_last_cnt;
    logic           w_gen_chg;
    logic [3:0]     w_cnt;
    logic           w_last;
    logic           w_hs;
    logic           w_acc;
    logic           w_hdr;
    logic [TOT-1:0] w_asm;

    always_comb begin
        w_last_cnt = 4'd0;
        case (gen_speed)
            2'd1:    w_last_cnt = 4'd15;
            2'd2:    w_last_cnt = 4'd7;
            default: w_last_cnt = 4'd0;
        endcase
    end

    // A mode switch restarts the symbol; the byte on this cycle becomes byte 0.
    assign w_gen_chg = (gen_speed != r_gen_q);
    assign w_cnt     = (w_gen_chg || r_state == S_IDLE) ? 4'd0 : r_byte_cnt;
    assign w_last    = (w_cnt == w_last_cnt);
    assign w_hs      = r_sym_valid && sym_ready;
    assign in_ready  = rst && enable && (gen_speed != 2'd3)
                     && !(w_last && r_sym_valid && !sym_ready);
    assign w_acc     = in_ready && (d_sel != 4'd9);
    assign w_hdr     = (w_cnt == 4'd0) ? (d_sel == 4'd8) : r_hdr_sel;

    always_comb begin
        w_asm = (w_cnt == 4'd0) ? '0 : r_stage;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (w_cnt == 4'(j)) begin
                    case (gen_speed)
                        2'd1:    w_asm[SYM_W*k + 4 + 8*j +: 8] = lane_tx[8*k +: 8];
                        2'd2:    w_asm[SYM_W*k + 2 + 8*j +: 8] = lane_tx[8*k +: 8];
                        default: w_asm[SYM_W*k + 8*j +: 8]     = lane_tx[8*k +: 8];
                    endcase
                end
            end
            case (gen_speed)
                2'd1:    w_asm[SYM_W*k +: 4] = w_hdr ? 4'b1010 : 4'b0101;
                2'd2:    w_asm[SYM_W*k +: 2] = w_hdr ? 2'b10 : 2'b01;
                default: ;
            endcase
        end
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 4'd0;
            r_hdr_sel   <= 1'b0;
            r_gen_q     <= 2'd0;
            r_stage     <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_new_sym   <= 1'b0;
            r_abort     <= 1'b0;
        end else if (!enable) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 4'd0;
            r_hdr_sel   <= 1'b0;
            r_gen_q     <= gen_speed;
            r_stage     <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_new_sym   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_gen_q   <= gen_speed;
            r_abort   <= w_gen_chg && (r_state == S_COLLECT);
            r_new_sym <= 1'b0;
            if (w_acc && w_last) begin
                r_sym       <= w_asm;
                r_sym_valid <= 1'b1;
                r_new_sym   <= 1'b1;
                r_byte_cnt  <= 4'd0;
                r_state     <= S_IDLE;
            end else begin
                if (w_hs) begin
                    r_sym_valid <= 1'b0;
                end
                if (w_acc) begin
                    r_stage    <= w_asm;
                    r_hdr_sel  <= w_hdr;
                    r_byte_cnt <= w_cnt + 4'd1;
                    r_state    <= S_COLLECT;
                end else if (w_gen_chg) begin
                    r_byte_cnt <= 4'd0;
                    r_state    <= S_IDLE;
                end
            end
        end
    end

`ifdef USB4_ENC_STATS_EN
    logic [15:0] r_sym_count;

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_sym_count <= 16'd0;
        end else if (!enable) begin
            r_sym_count <= 16'd0;
        end else if (w_hs && r_sym_count != 16'hFFFF) begin
            r_sym_count <= r_sym_count + 16'd1;
        end
    end

    assign sym_count = r_sym_count;
`endif

    assign sym_out   = r_sym;
    assign sym_valid = r_sym_valid;
    assign new_sym   = r_new_sym;
    assign abort     = r_abort;

endmodule

// File: tb/tb_usb4_lane_encoder_gen.sv
// Directed testbench for usb4_lane_encoder_gen (2 lanes, 132-bit slices).
module tb_usb4_lane_encoder_gen;

    localparam int NL  = 2;
    localparam int SW  = 132;
    localparam int TOT = SW * NL;

    logic           enc_clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [1:0]     gen_speed;
    logic [3:0]     d_sel;
    logic [8*NL-1:0] lane_tx;
    logic           in_ready;
    logic [TOT-1:0] sym_out;
    logic           sym_valid;
    logic           sym_ready;
    logic           new_sym;
    logic           abort;

    int n_chk = 0;
    int n_err = 0;

    always #5 enc_clk = ~enc_clk;

    usb4_lane_encoder_gen #(.NUM_LANES(NL), .SYM_W(SW)) dut (
        .enc_clk   (enc_clk),
        .rst       (rst),
        .enable    (enable),
        .gen_speed (gen_speed),
        .d_sel     (d_sel),
        .lane_tx   (lane_tx),
        .in_ready  (in_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .new_sym   (new_sym),
        .abort     (abort)
    );

    task automatic chk(input string tag, input logic [TOT-1:0] got,
                       input logic [TOT-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge enc_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1);
        lane_tx = {b1, b0};
        tick();
    endtask

    // Gen3 symbol: lane0 bytes s+i, lane1 bytes ~(s+i), data header.
    function automatic logic [TOT-1:0] mk3(input logic [7:0] s);
        logic [TOT-1:0] v;
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            b = s + 8'(i);
            v[4 + 8*i +: 8]      = b;
            v[SW + 4 + 8*i +: 8] = ~b;
        end
        v[3:0]       = 4'hA;
        v[SW+3 : SW] = 4'hA;
        return v;
    endfunction

    int acc;
    int nsym;
    logic ok;
    logic stalled;
    logic have_held;
    logic [TOT-1:0] held;

    initial begin
        rst = 1'b0; enable = 1'b0; gen_speed = 2'd1; d_sel = 4'd9;
        lane_tx = '0; sym_ready = 1'b1;
        #12;
        chk("rst_sym", sym_out, '0);
        chk("rst_valid", sym_valid, 0);
        chk("rst_new", new_sym, 0);
        chk("rst_abort", abort, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b1; enable = 1'b1;
        tick();

        // Gen3 data symbol
        d_sel = 4'd8; nsym = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 8'(8'hF0 + i));
            if (new_sym && i < 15) nsym++;
        end
        chk("g3_early_new", nsym, 0);
        chk("g3_new", new_sym, 1);
        chk("g3_valid", sym_valid, 1);
        chk("g3_sym", sym_out,
            {128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 4'hA,
             128'h0F0E0D0C0B0A09080706050403020100, 4'hA});
        d_sel = 4'd9;
        tick();
        chk("g3_drain", sym_valid, 0);
        chk("g3_pulse", new_sym, 0);

        // Gen2 ordered-set header latched on byte 0
        gen_speed = 2'd2; d_sel = 4'd3;
        send(8'h11, 8'h21);
        chk("g2_noabort", abort, 0);
        d_sel = 4'd8;
        for (int i = 1; i < 8; i++) send(8'(8'h11 + i), 8'(8'h21 + i));
        chk("g2_new", new_sym, 1);
        chk("g2_lane0", sym_out[SW-1:0],
            {66'b0, 64'h1817161514131211, 2'b01});
        chk("g2_lane1", sym_out[TOT-1:SW],
            {66'b0, 64'h2827262524232221, 2'b01});
        d_sel = 4'd9;
        tick();

        // Gen3 backpressure for 40 cycles
        gen_speed = 2'd1; d_sel = 4'd8; sym_ready = 1'b0;
        acc = 0; stalled = 1'b0; have_held = 1'b0; held = '0;
        repeat (40) begin
            lane_tx = {~8'(acc), 8'(acc)};
            #1 ok = in_ready;
            @(posedge enc_clk);
            #1;
            if (ok) acc++;
            else stalled = 1'b1;
            if (sym_valid && !have_held) begin
                held = sym_out;
                have_held = 1'b1;
            end
        end
        chk("bp_accepted", acc, 31);
        chk("bp_stalled", stalled, 1);
        chk("bp_ready_low", in_ready, 0);
        chk("bp_hold", sym_out, mk3(8'h00));
        chk("bp_stable", sym_out, held);
        sym_ready = 1'b1;
        tick();
        chk("bp_new", new_sym, 1);
        chk("bp_valid", sym_valid, 1);
        chk("bp_symB", sym_out, mk3(8'h10));
        d_sel = 4'd9;
        tick();
        chk("bp_drain", sym_valid, 0);

        // Gen2 -> Gen3 switch mid-symbol
        gen_speed = 2'd2; d_sel = 4'd8;
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), ~8'(8'h40 + i));
        chk("ab_none", abort, 0);
        gen_speed = 2'd1;
        send(8'h60, ~8'h60);
        chk("ab_pulse", abort, 1);
        chk("ab_valid", sym_valid, 0);
        for (int i = 1; i < 16; i++) begin
            send(8'(8'h60 + i), ~8'(8'h60 + i));
            if (i == 1) chk("ab_once", abort, 0);
            if (i == 14) chk("ab_no66", sym_valid, 0);
        end
        chk("ab_new", new_sym, 1);
        chk("ab_sym", sym_out, mk3(8'h60));
        d_sel = 4'd9;
        tick();

        // Gen4 pass-through
        gen_speed = 2'd0; d_sel = 4'd8;
        send(8'hA5, 8'h3C);
        chk("g4_v1", sym_valid, 1);
        chk("g4_n1", new_sym, 1);
        chk("g4_s1", sym_out, {124'b0, 8'h3C, 124'b0, 8'hA5});
        send(8'h5A, 8'hC3);
        chk("g4_v2", sym_valid, 1);
        chk("g4_n2", new_sym, 1);
        chk("g4_s2", sym_out, {124'b0, 8'hC3, 124'b0, 8'h5A});
        d_sel = 4'd9;
        tick();
        chk("g4_drain", sym_valid, 0);

        // Reserved speed
        gen_speed = 2'd3; d_sel = 4'd8;
        #1 chk("rsv_ready", in_ready, 0);
        tick();
        chk("rsv_valid", sym_valid, 0);

        // enable low mid-symbol
        gen_speed = 2'd1; d_sel = 4'd8; sym_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), ~8'(8'h70 + i));
        enable = 1'b0;
        tick();
        chk("en_sym", sym_out, '0);
        chk("en_valid", sym_valid, 0);
        chk("en_abort", abort, 0);
        chk("en_ready", in_ready, 0);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), ~8'(8'h80 + i));
        chk("en_restart", sym_out, mk3(8'h80));
        d_sel = 4'd9;
        tick();

        // rst low mid-symbol with a held symbol
        sym_ready = 1'b0; d_sel = 4'd8;
        for (int i = 0; i < 16; i++) send(8'(8'h90 + i), ~8'(8'h90 + i));
        for (int i = 0; i < 3; i++) send(8'(8'hB0 + i), ~8'(8'hB0 + i));
        chk("rs_pre", sym_valid, 1);
        rst = 1'b0;
        #1;
        chk("rs_sym", sym_out, '0);
        chk("rs_valid", sym_valid, 0);
        chk("rs_ready", in_ready, 0);
        chk("rs_new", new_sym, 0);
        rst = 1'b1; sym_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), ~8'(8'hC0 + i));
        chk("rs_new2", new_sym, 1);
        chk("rs_restart", sym_out, mk3(8'hC0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
